// File: rtl/stream_upsize_buffered.sv
// rtl/stream_upsize_buffered.sv - registered narrow-to-wide stream packer with per-lane keep
// The accumulator fills lane by lane; a completing beat moves the word into the output register.
module stream_upsize_buffered #(
   parameter int T_DATA_WIDTH = 4,
   parameter int T_DATA_RATIO = 2
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic [T_DATA_WIDTH-1:0]                    s_data_i,
   input  logic                                       s_last_i,
   input  logic                                       s_valid_i,
   output logic                                       s_ready_o,
   output logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0]  m_data_o,
   output logic [T_DATA_RATIO-1:0]                    m_keep_o,
   output logic                                       m_last_o,
   output logic                                       m_valid_o,
   input  logic                                       m_ready_i
);

   localparam int CW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;

   generate
      if (T_DATA_RATIO < 2) begin : g_bad_ratio
         $error("stream_upsize_buffered: T_DATA_RATIO must be >= 2");
      end
   endgenerate

   typedef logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] word_t;

   word_t                   acc_data_q, acc_data_d;
   logic [T_DATA_RATIO-1:0] acc_keep_q, acc_keep_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   word_t                   out_data_q, out_data_d;
   logic [T_DATA_RATIO-1:0] out_keep_q, out_keep_d;
   logic                    out_last_q, out_last_d;
   logic                    out_valid_q, out_valid_d;

   logic                    s_xfer;
   logic                    completing;
   logic [T_DATA_RATIO-1:0] lane_bit;

   // Ready looks only at the output register, so an accepted beat can never overwrite a pending word.
   assign s_ready_o  = !rst_i && (!out_valid_q || m_ready_i);
   assign s_xfer     = s_valid_i && s_ready_o;
   assign completing = s_last_i || (cnt_q == CW'(T_DATA_RATIO - 1));
   assign lane_bit   = {{(T_DATA_RATIO-1){1'b0}}, 1'b1} << cnt_q;

   always_comb begin
      acc_data_d  = acc_data_q;
      acc_keep_d  = acc_keep_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;

      if (out_valid_q && m_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (s_xfer) begin
         if (completing) begin
            out_data_d          = acc_data_q;
            out_data_d[cnt_q]   = s_data_i;
            out_keep_d          = acc_keep_q | lane_bit;
            out_last_d          = s_last_i;
            out_valid_d         = 1'b1;
            acc_data_d          = '0;
            acc_keep_d          = '0;
            cnt_d               = '0;
         end else begin
            acc_data_d[cnt_q]   = s_data_i;
            acc_keep_d          = acc_keep_q | lane_bit;
            cnt_d               = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_data_q  <= '0;
         acc_keep_q  <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_data_q  <= acc_data_d;
         acc_keep_q  <= acc_keep_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign m_data_o  = out_data_q;
   assign m_keep_o  = out_keep_q;
   assign m_last_o  = out_last_q;
   assign m_valid_o = out_valid_q;

endmodule
